vend_sequencer: RTL and testbench

//  Transaction controller for the vending datapath: accepts coins into a credit register,

---
 rtl/vend_pkg.sv | 34 +++
 rtl/vend_sel_ring.sv | 33 +++
 rtl/vend_sequencer.sv | 152 +++++++++++++++
 tb/tb_vend_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared constants and decode helpers for the vending transaction controller.
package vend_pkg;

   localparam logic [1:0] StIdle     = 2'd0;
   localparam logic [1:0] StCredit   = 2'd1;
   localparam logic [1:0] StDispense = 2'd2;
   localparam logic [1:0] StChange   = 2'd3;

   localparam logic [1:0] Coin1  = 2'b00;
   localparam logic [1:0] Coin5  = 2'b01;
   localparam logic [1:0] Coin10 = 2'b10;
   localparam logic [1:0] Coin20 = 2'b11;

   localparam int unsigned MaxCreditDef = 99;

   function automatic logic [6:0] coin_value(input logic [1:0] code);
      logic [6:0] v;
      v = 7'd1;
      case (code)
         Coin1:   v = 7'd1;
         Coin5:   v = 7'd5;
         Coin10:  v = 7'd10;
         Coin20:  v = 7'd20;
         default: v = 7'd1;
      endcase
      return v;
   endfunction

   // Price table is packed 4 bits per item, item 0 in the least significant nibble.
   function automatic logic [3:0] price_of(input logic [31:0] prices, input logic [2:0] idx);
      return prices[{idx, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/vend_sel_ring.sv
// Product cursor: wrapping up/down counter over 0..NUM_ITEMS-1 with a move enable.
module vend_sel_ring #(
   parameter int unsigned NUM_ITEMS = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       up,
   input  logic       down,
   output logic [2:0] idx
);

   localparam logic [2:0] Last = 3'(NUM_ITEMS - 1);

   logic [2:0] idx_q, idx_d;

   always_comb begin
      idx_d = idx_q;
      if (en && up && !down) begin
         idx_d = (idx_q == Last) ? 3'd0 : idx_q + 3'd1;
      end else if (en && down && !up) begin
         idx_d = (idx_q == 3'd0) ? Last : idx_q - 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) idx_q <= 3'd0;
      else     idx_q <= idx_d;
   end

   assign idx = idx_q;

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction FSM: coin credit, cursor, dispense and change handshakes.
// Define VEND_TIMEOUT_EN to auto-refund credit after TIMEOUT_CYC idle cycles.
module vend_sequencer
   import vend_pkg::*;
#(
   parameter int unsigned            NUM_ITEMS   = 5,
   parameter logic [4*NUM_ITEMS-1:0] PRICES      = {4'd8, 4'd10, 4'd6, 4'd5, 4'd7},
   parameter int unsigned            MAX_CREDIT  = MaxCreditDef,
   parameter int unsigned            TIMEOUT_CYC = 1000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 coin_valid,
   input  logic [1:0]           coin_code,
   output logic                 coin_ready,
   input  logic                 btn_left,
   input  logic                 btn_right,
   input  logic                 btn_confirm,
   input  logic                 btn_cancel,
   output logic [2:0]           sel_idx,
   output logic [3:0]           sel_price,
   output logic [6:0]           credit,
   output logic [NUM_ITEMS-1:0] item_afford,
   output logic                 deny,
   output logic                 disp_req,
   output logic [2:0]           disp_item,
   input  logic                 disp_ack,
   output logic                 chg_req,
   output logic [6:0]           chg_amount,
   input  logic                 chg_ack,
   output logic                 busy
);

   localparam logic [31:0] PriceVec = 32'(PRICES);

   logic [1:0] state_q, state_d;
   logic [6:0] credit_q, credit_d;
   logic [2:0] disp_item_q, disp_item_d;
   logic [6:0] chg_amount_q, chg_amount_d;
   logic       deny_q, deny_d;
   logic [6:0] coin_val, credit_sum, disp_rem;
   logic       coin_acc, in_shop, timeout;

   assign in_shop    = (state_q == StIdle) || (state_q == StCredit);
   assign coin_val   = coin_value(coin_code);
   assign coin_ready = in_shop && (({1'b0, credit_q} + {1'b0, coin_val}) <= 8'(MAX_CREDIT));
   assign coin_acc   = coin_valid && coin_ready;
   assign credit_sum = credit_q + coin_val;
   assign disp_rem   = credit_q - {3'b000, price_of(PriceVec, disp_item_q)};

`ifdef VEND_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

   logic [TmoW-1:0] tmo_q;
   logic            activity;

   assign activity = coin_acc || btn_left || btn_right || btn_confirm || btn_cancel;
   assign timeout  = (state_q == StCredit) && !activity && (tmo_q == TmoW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst)                       tmo_q <= '0;
      else if (activity)             tmo_q <= '0;
      else if (state_q == StCredit)  tmo_q <= tmo_q + 1'b1;
   end
`else
   assign timeout = 1'b0;
`endif

   vend_sel_ring #(
      .NUM_ITEMS (NUM_ITEMS)
   ) u_sel_ring (
      .clk  (clk),
      .rst  (rst),
      .en   (in_shop),
      .up   (btn_right),
      .down (btn_left),
      .idx  (sel_idx)
   );

   assign sel_price = price_of(PriceVec, sel_idx);

   always_comb begin
      state_d      = state_q;
      credit_d     = credit_q;
      disp_item_d  = disp_item_q;
      chg_amount_d = chg_amount_q;
      deny_d       = 1'b0;
      if (coin_acc) credit_d = credit_sum;
      case (state_q)
         StIdle: begin
            if (coin_acc) state_d = StCredit;
            // Deny is suppressed when an accepted coin moves us out of IDLE this cycle.
            else if (btn_confirm && !btn_cancel) deny_d = 1'b1;
         end
         StCredit: begin
            if (btn_cancel || timeout) begin
               state_d      = StChange;
               chg_amount_d = credit_d;
            end else if (btn_confirm) begin
               if (credit_q >= {3'b000, sel_price}) begin
                  state_d     = StDispense;
                  disp_item_d = sel_idx;
               end else begin
                  deny_d = 1'b1;
               end
            end
         end
         StDispense: begin
            if (disp_ack) begin
               credit_d = disp_rem;
               state_d  = (disp_rem != 7'd0) ? StCredit : StIdle;
            end
         end
         StChange: begin
            if (chg_ack) begin
               credit_d = 7'd0;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         credit_q     <= 7'd0;
         disp_item_q  <= 3'd0;
         chg_amount_q <= 7'd0;
         deny_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         credit_q     <= credit_d;
         disp_item_q  <= disp_item_d;
         chg_amount_q <= chg_amount_d;
         deny_q       <= deny_d;
      end
   end

   for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_afford
      assign item_afford[i] = credit_q >= {3'b000, price_of(PriceVec, 3'(i))};
   end

   assign credit     = credit_q;
   assign deny       = deny_q;
   assign disp_req   = (state_q == StDispense);
   assign disp_item  = disp_item_q;
   assign chg_req    = (state_q == StChange);
   assign chg_amount = chg_amount_q;
   assign busy       = disp_req || chg_req;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer (prices item0..4 = 7,5,6,10,8).
module tb_vend_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       coin_valid;
   logic [1:0] coin_code;
   logic       coin_ready;
   logic       btn_left, btn_right, btn_confirm, btn_cancel;
   logic [2:0] sel_idx;
   logic [3:0] sel_price;
   logic [6:0] credit;
   logic [4:0] item_afford;
   logic       deny;
   logic       disp_req;
   logic [2:0] disp_item;
   logic       disp_ack;
   logic       chg_req;
   logic [6:0] chg_amount;
   logic       chg_ack;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   vend_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .coin_valid  (coin_valid),
      .coin_code   (coin_code),
      .coin_ready  (coin_ready),
      .btn_left    (btn_left),
      .btn_right   (btn_right),
      .btn_confirm (btn_confirm),
      .btn_cancel  (btn_cancel),
      .sel_idx     (sel_idx),
      .sel_price   (sel_price),
      .credit      (credit),
      .item_afford (item_afford),
      .deny        (deny),
      .disp_req    (disp_req),
      .disp_item   (disp_item),
      .disp_ack    (disp_ack),
      .chg_req     (chg_req),
      .chg_amount  (chg_amount),
      .chg_ack     (chg_ack),
      .busy        (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic coin(input logic [1:0] code);
      coin_valid = 1'b1;
      coin_code  = code;
      step();
      coin_valid = 1'b0;
   endtask

   task automatic press_right();
      btn_right = 1'b1;
      step();
      btn_right = 1'b0;
   endtask

   task automatic press_left();
      btn_left = 1'b1;
      step();
      btn_left = 1'b0;
   endtask

   task automatic press_confirm();
      btn_confirm = 1'b1;
      step();
      btn_confirm = 1'b0;
   endtask

   task automatic press_cancel();
      btn_cancel = 1'b1;
      step();
      btn_cancel = 1'b0;
   endtask

   task automatic ack_disp();
      disp_ack = 1'b1;
      step();
      disp_ack = 1'b0;
   endtask

   task automatic ack_chg();
      chg_ack = 1'b1;
      step();
      chg_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      coin_valid = 1'b0; coin_code = 2'b00;
      btn_left = 1'b0; btn_right = 1'b0; btn_confirm = 1'b0; btn_cancel = 1'b0;
      disp_ack = 1'b0; chg_ack = 1'b0;
      step(); step();
      rst = 1'b0;
      step();

      // Reset state
      chk("rst_credit", credit, 0);
      chk("rst_sel_idx", sel_idx, 0);
      chk("rst_sel_price", sel_price, 7);
      chk("rst_disp_req", disp_req, 0);
      chk("rst_chg_req", chg_req, 0);
      chk("rst_deny", deny, 0);
      chk("rst_busy", busy, 0);
      chk("rst_coin_ready", coin_ready, 1);
      chk("rst_afford", item_afford, 5'b00000);

      // Coins 5,1,1 -> 7; prices 7,5,6,10,8 give afford 00111
      coin(2'b01); coin(2'b00); coin(2'b00);
      chk("c7_credit", credit, 7);
      chk("c7_afford", item_afford, 5'b00111);
      chk("c7_busy", busy, 0);

      // Buy item 0, ack held off 3 cycles; cursor frozen while dispensing
      press_confirm();
      chk("buy_disp_req1", disp_req, 1);
      chk("buy_disp_item", disp_item, 0);
      chk("buy_busy", busy, 1);
      chk("buy_coin_ready", coin_ready, 0);
      press_right();
      chk("buy_disp_req2", disp_req, 1);
      chk("buy_cursor_frozen", sel_idx, 0);
      step();
      chk("buy_disp_req3", disp_req, 1);
      ack_disp();
      chk("buy_done_req", disp_req, 0);
      chk("buy_done_credit", credit, 0);
      chk("buy_done_busy", busy, 0);

      // Insufficient credit -> deny pulse
      coin(2'b01);
      press_confirm();
      chk("deny_pulse", deny, 1);
      chk("deny_no_req", disp_req, 0);
      chk("deny_credit", credit, 5);
      step();
      chk("deny_clear", deny, 0);

      // Credit ceiling
      coin(2'b11); coin(2'b11); coin(2'b11); coin(2'b11); coin(2'b10);
      chk("c95_credit", credit, 95);
      coin_valid = 1'b1; coin_code = 2'b10; #1;
      chk("c95_ready_10", coin_ready, 0);
      step();
      coin_valid = 1'b0;
      chk("c95_hold", credit, 95);
      coin(2'b00);
      chk("c96_credit", credit, 96);
      coin_code = 2'b01; #1;
      chk("c96_ready_5", coin_ready, 0);
      coin_code = 2'b00; #1;
      chk("c96_ready_1", coin_ready, 1);

      // Stray ack while in CREDIT is ignored
      ack_chg();
      chk("stray_ack_credit", credit, 96);

      // Cancel refunds everything
      press_cancel();
      chk("cancel96_req", chg_req, 1);
      chk("cancel96_amt", chg_amount, 96);
      chk("cancel96_busy", busy, 1);
      ack_chg();
      chk("cancel96_credit", credit, 0);
      chk("cancel96_req_off", chg_req, 0);

      // Cancel in IDLE: no effect
      press_cancel();
      chk("idle_cancel", chg_req, 0);

      // Cursor wrap
      coin(2'b11);
      press_right(); press_right(); press_right(); press_right();
      chk("cur_4", sel_idx, 4);
      chk("cur_4_price", sel_price, 8);
      press_right();
      chk("cur_wrap_up", sel_idx, 0);
      press_left();
      chk("cur_wrap_down", sel_idx, 4);
      btn_left = 1'b1; btn_right = 1'b1;
      step();
      btn_left = 1'b0; btn_right = 1'b0;
      chk("cur_both", sel_idx, 4);
      press_right();
      press_cancel();
      chk("cancel20_amt", chg_amount, 20);
      ack_chg();
      chk("cancel20_credit", credit, 0);

      // Multi-buy: 20 credit, item 3 (price 10), remainder 10 stays
      coin(2'b11);
      press_right(); press_right(); press_right();
      chk("mb_price", sel_price, 10);
      press_confirm();
      chk("mb_disp_item", disp_item, 3);
      ack_disp();
      chk("mb_credit", credit, 10);
      chk("mb_busy", busy, 0);
      chk("mb_afford", item_afford, 5'b11111);

      // Coin + confirm: judged on pre-coin credit 10, coin 5 added
      coin_valid = 1'b1; coin_code = 2'b01; btn_confirm = 1'b1;
      step();
      coin_valid = 1'b0; btn_confirm = 1'b0;
      chk("cc_disp_req", disp_req, 1);
      chk("cc_credit", credit, 15);
      ack_disp();
      chk("cc_rem", credit, 5);

      // Coin + cancel: refund includes the coin
      coin_valid = 1'b1; coin_code = 2'b00; btn_cancel = 1'b1;
      step();
      coin_valid = 1'b0; btn_cancel = 1'b0;
      chk("ccan_amt", chg_amount, 6);
      chk("ccan_req", chg_req, 1);
      ack_chg();
      chk("ccan_credit", credit, 0);

      // Reset mid-handshake
      coin(2'b11);
      press_confirm();
      chk("rmid_req", disp_req, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rmid_req_drop", disp_req, 0);
      chk("rmid_credit", credit, 0);
      chk("rmid_sel", sel_idx, 0);

`ifdef VEND_TIMEOUT_EN
      begin
         int waited;
         coin(2'b10);
         waited = 0;
         while (!chg_req && waited < 1100) begin
            step();
            waited++;
         end
         chk("tmo_req", chg_req, 1);
         chk("tmo_amt", chg_amount, 10);
         ack_chg();
         chk("tmo_credit", credit, 0);
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
